// File: rtl/rst_seq.sv
// rst_seq: reset sequencer downstream of the PLL / clock divider.
// Waits for a filtered PLL lock, then releases STAGES active-low reset
// domains one at a time (bit 0 first), HOLD_CYCLES apart. Drops every
// domain on lock loss. A handshaked software request re-sequences from RUN
// and is acknowledged with a one-cycle pulse once RUN is reached again.
// Optional feature macro: RST_SEQ_REVERSE_ASSERT_EN. When defined, a
// software reset drops the stages highest-first, HOLD_CYCLES apart.
// Reset is synchronous and active-low (n_reset).
module rst_seq #(
  parameter int STAGES      = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int LOCK_FILTER = 8
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              pll_lock,
  input  logic              sw_rst_req,
  output logic              sw_rst_ack,
  output logic [STAGES-1:0] n_rst_out,
  output logic              ready
);

  typedef enum logic [1:0] {
    S_WAIT_LOCK,
    S_RELEASE,
    S_RUN,
    S_ASSERT
  } state_e;

  localparam logic [15:0] HOLD_TERM = 16'(HOLD_CYCLES);
  localparam logic [7:0]  FILT_TERM = 8'(LOCK_FILTER);
  localparam logic [2:0]  LAST_IDX  = 3'(STAGES - 1);

  // Synchroniser and request edge register.
  logic lock_meta_q;
  logic lock_s_q;
  logic req_q;

  // FSM state and registered outputs.
  state_e            state_q,   state_d;
  logic [7:0]        filt_q,    filt_d;
  logic [15:0]       hold_q,    hold_d;
  logic [2:0]        idx_q,     idx_d;
  logic              pending_q, pending_d;
  logic [STAGES-1:0] n_rst_q,   n_rst_d;
  logic              ready_q,   ready_d;
  logic              ack_q,     ack_d;

  logic req_edge;

  // Two-flop lock synchroniser plus a registered copy of the request level.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, whatever the block order.
    if (!n_reset) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      req_q       <= 1'b0;
    end else begin
      lock_meta_q <= pll_lock;
      lock_s_q    <= lock_meta_q;
      req_q       <= sw_rst_req;
    end
  end

  assign req_edge = sw_rst_req & ~req_q;

  // Next-state logic: lock filter, stage release, lock loss, software reset.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d   = state_q;
    filt_d    = filt_q;
    hold_d    = hold_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    n_rst_d   = n_rst_q;
    ready_d   = ready_q;
    ack_d     = 1'b0;

    if (state_q == S_WAIT_LOCK) begin
      if (!lock_s_q) begin
        filt_d = '0;
      end else if (filt_q + 8'd1 == FILT_TERM) begin
        state_d = S_RELEASE;
        filt_d  = '0;
        hold_d  = '0;
        idx_d   = '0;
      end else begin
        filt_d = filt_q + 8'd1;
      end
    end else begin
      // A request seen in RUN is remembered even if lock loss wins this edge.
      if (state_q == S_RUN && req_edge) begin
        pending_d = 1'b1;
      end

      if (!lock_s_q) begin
        state_d = S_WAIT_LOCK;
        n_rst_d = '0;
        ready_d = 1'b0;
        filt_d  = '0;
        hold_d  = '0;
        idx_d   = '0;
      end else begin
        case (state_q)
          S_RELEASE: begin
            if (hold_q + 16'd1 == HOLD_TERM) begin
              hold_d  = '0;
              n_rst_d = (n_rst_q << 1) | STAGES'(1);
              idx_d   = idx_q + 3'd1;
              if (idx_q == LAST_IDX) begin
                state_d = S_RUN;
                ready_d = 1'b1;
                idx_d   = '0;
                if (pending_q) begin
                  ack_d     = 1'b1;
                  pending_d = 1'b0;
                end
              end
            end else begin
              hold_d = hold_q + 16'd1;
            end
          end

          S_RUN: begin
            if (req_edge) begin
              state_d = S_ASSERT;
              ready_d = 1'b0;
              hold_d  = '0;
`ifdef RST_SEQ_REVERSE_ASSERT_EN
              // Highest stage drops now; idx counts the stages still up.
              n_rst_d = n_rst_q >> 1;
              idx_d   = LAST_IDX;
`else
              n_rst_d = '0;
              idx_d   = '0;
`endif
            end
          end

          S_ASSERT: begin
            if (hold_q + 16'd1 == HOLD_TERM) begin
              hold_d = '0;
              if (idx_q != 3'd0) begin
                // Reverse assert only: drop the next lower stage.
                idx_d   = idx_q - 3'd1;
                n_rst_d = n_rst_q >> 1;
              end else begin
                state_d = S_RELEASE;
              end
            end else begin
              hold_d = hold_q + 16'd1;
            end
          end

          default: begin
          end
        endcase
      end
    end
  end

  // FSM and output registers.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q   <= S_WAIT_LOCK;
      filt_q    <= '0;
      hold_q    <= '0;
      idx_q     <= '0;
      pending_q <= 1'b0;
      n_rst_q   <= '0;
      ready_q   <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      filt_q    <= filt_d;
      hold_q    <= hold_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      n_rst_q   <= n_rst_d;
      ready_q   <= ready_d;
      ack_q     <= ack_d;
    end
  end

  assign n_rst_out  = n_rst_q;
  assign ready      = ready_q;
  assign sw_rst_ack = ack_q;

endmodule
